// File: rtl/ps2_key_decoder_if.sv
// Signal bundle between the PS/2 connector, the key decoder and the input manager.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       raw_left;
  logic       raw_right;
  logic       raw_down;
  logic       raw_rotate;
  logic       raw_drop;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  raw_left, raw_right, raw_down, raw_rotate, raw_drop,
    input  byte_valid, byte_data, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output raw_left, raw_right, raw_down, raw_rotate, raw_drop,
    output byte_valid, byte_data, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frame checking, E0/F0 prefix tracking and one held level
// per game key (left, right, down, rotate, drop).
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic             clk,
  input  logic             rst,
  ps2_key_decoder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  logic             r_clk_s1, r_clk_s2, r_clk_s3;
  logic             r_dat_s1, r_dat_s2;
  state_t           r_state;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic [CNT_W-1:0] r_cnt;
  logic             r_byte_valid;
  logic [7:0]       r_byte_data;
  logic             r_frame_err;
  logic             r_ext, r_brk;
  logic [4:0]       r_keys;
  logic             w_fall;
  logic             w_timeout;
  logic [4:0]       w_mask;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Key bit order is {drop, rotate, down, right, left}.
  function automatic logic [4:0] key_mask(input logic ext, input logic [7:0] code);
    logic [4:0] mask;
    case ({ext, code})
      9'h16B:  mask = 5'b00001;
      9'h174:  mask = 5'b00010;
      9'h172:  mask = 5'b00100;
      9'h175:  mask = 5'b01000;
      9'h029:  mask = 5'b10000;
      default: mask = 5'b00000;
    endcase
    return mask;
  endfunction

  // Synchronisers idle high so a reset release never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= bus.ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= bus.ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall    = r_clk_s3 & ~r_clk_s2;
  assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_mask    = key_mask(r_ext, r_byte_data);

  // Frame receiver; a timeout behaves like an extra failing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_parity     <= 1'b0;
      r_cnt        <= '0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'h00;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_fall || r_state == ST_IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_timeout) begin
        r_state     <= ST_IDLE;
        r_frame_err <= 1'b1;
        r_cnt       <= '0;
      end else if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= 3'd0;
              r_shift   <= 8'h00;
            end
          end
          ST_DATA: begin
            r_shift <= {r_dat_s2, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          ST_PARITY: begin
            r_parity <= r_dat_s2;
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            if (r_dat_s2 && odd_parity_ok(r_shift, r_parity)) begin
              r_byte_valid <= 1'b1;
              r_byte_data  <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Prefix tracking and key levels; any frame error forgets a pending prefix.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_keys <= 5'b00000;
    end else if (r_frame_err) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_byte_valid) begin
      if (r_byte_data == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_byte_data == 8'hF0) begin
        r_brk <= 1'b1;
      end else begin
        r_keys <= r_brk ? (r_keys & ~w_mask) : (r_keys | w_mask);
        r_ext  <= 1'b0;
        r_brk  <= 1'b0;
      end
    end
  end

  assign bus.raw_left   = r_keys[0];
  assign bus.raw_right  = r_keys[1];
  assign bus.raw_down   = r_keys[2];
  assign bus.raw_rotate = r_keys[3];
  assign bus.raw_drop   = r_keys[4];
  assign bus.byte_valid = r_byte_valid;
  assign bus.byte_data  = r_byte_data;
  assign bus.frame_err  = r_frame_err;

endmodule
